uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between NUM_REQ byte-stream requesters, for example the debug/status reporter and the MIDI echo path. The block arbitrates round-robin at packet granularity. The grant is held until the requester's last byte has been sent. Each byte is handed to the transmitter as a one-cycle tx_start pulse, and the block waits for tx_done before the next byte. An optional inter-packet idle gap, counted in 16x oversampling ticks, is inserted after every packet.

---
 rtl/uart_tx_arbiter.sv | 106 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular sharing of one UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int GAP_TICKS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_din,
  input  logic                 tx_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
  typedef enum logic [1:0] {ARB, SEND, WAIT, GAP} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0] last_grant_q, last_grant_d, win_idx, rr_idx;
  logic [IW:0] rr_sum;
  logic win_found;
  logic tx_start_q, tx_start_d, last_flag_q, last_flag_d;
  logic [7:0] tx_din_q, tx_din_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic gap_end;
  assign gap_end   = s_tick && int'(gap_cnt_q) == GAP_TICKS - 1;
  assign req_ready = state_q == SEND ? req_valid & grant_q : '0;
  assign tx_start  = tx_start_q;
  assign tx_din    = tx_din_q;
  assign grant     = grant_q;
  assign busy      = state_q != ARB;
  // round-robin search: first valid requester after the previous owner, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant_q;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_sum = {1'b0, last_grant_q} + (IW+1)'(k);
      rr_idx = rr_sum >= (IW+1)'(NUM_REQ) ? IW'(rr_sum - (IW+1)'(NUM_REQ)) : IW'(rr_sum);
      if (!win_found && req_valid[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end
  // packet FSM: arbitrate, hand one byte at a time to the transmitter, optional idle gap
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_start_d   = 1'b0;
    tx_din_d     = tx_din_q;
    last_flag_d  = last_flag_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ARB: if (win_found) begin
        grant_d      = NUM_REQ'(1) << win_idx;
        last_grant_d = win_idx;
        state_d      = SEND;
      end
      SEND: if (req_valid[last_grant_q]) begin
        tx_din_d    = req_data[{last_grant_q, 3'b000} +: 8];
        tx_start_d  = 1'b1;
        last_flag_d = req_last[last_grant_q];
        state_d     = WAIT;
      end
      WAIT: if (tx_done) begin
        state_d   = !last_flag_q ? SEND : GAP_TICKS > 0 ? GAP : ARB;
        gap_cnt_d = '0;
        grant_d   = last_flag_q && GAP_TICKS == 0 ? '0 : grant_q;
      end
      GAP: if (s_tick) begin
        state_d   = gap_end ? ARB : GAP;
        grant_d   = gap_end ? '0 : grant_q;
        gap_cnt_d = gap_cnt_q + CW'(1);
      end
      default: state_d = ARB;
    endcase
  end
  // state registers with synchronous active-low reset; last owner starts at the top so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      tx_start_q   <= 1'b0;
      tx_din_q     <= 8'h00;
      last_flag_q  <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_start_q   <= tx_start_d;
      tx_din_q     <= tx_din_d;
      last_flag_q  <= last_flag_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and transmitter against an event-level reference model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int GAP = 4;
  logic clk = 1'b0, reset_n = 1'b0, s_tick = 1'b0, tx_done = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic tx_start, busy;
  logic [7:0] tx_din;
  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .req_valid(req_valid),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done(tx_done),
    .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [8:0] rq [N][$];
  bit acc [N];
  int stall [N];
  bit rand_mode = 0, chk_en = 0;
  int owner = -1, last_owner = N - 1, ticks = 0, cd = 0, cyc = 0;
  bit want = 0, outst = 0, out_last = 0, pend = 0, in_gap = 0, prev_start = 0, gap_meas = 0;
  logic [7:0] exp_din = 8'h00;
  int glog[$];
  logic [7:0] tlog[$];
  int gap_rec[$];
  int first_valid_cyc = -1, first_ready_cyc = -1, gap_cnt_meas = 0, total = 0;
  int n_cmp = 0, n_bad = 0;
  int exp_g[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_t[7] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hB5};
  logic [7:0] exp_c[4] = '{8'h61, 8'h62, 8'h70, 8'h71};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drive();
    @(posedge clk);
    #1;
    cyc++;
    s_tick = ($urandom_range(0, 2) == 0);
    tx_done = 1'b0;
    if (cd > 0) begin
      cd--;
      tx_done = (cd == 0);
    end else if (!outst && $urandom_range(0, 15) == 0) tx_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && !acc[i])) begin
        acc[i] = 0;
        if (stall[i] > 0) stall[i]--;
        else if (rand_mode && $urandom_range(0, 60) == 0) stall[i] = $urandom_range(5, 60);
        req_valid[i] = rq[i].size() > 0 && stall[i] == 0 && (!rand_mode || $urandom_range(0, 3) != 0);
        req_data[8*i +: 8] = req_valid[i] ? rq[i][0][7:0] : 8'($urandom);
        req_last[i] = req_valid[i] ? rq[i][0][8] : 1'($urandom);
        if (req_valid[i] && first_valid_cyc < 0) first_valid_cyc = cyc;
      end
    end
  endtask

  task automatic observe();
    logic [N-1:0] eg;
    @(negedge clk);
    if (!chk_en) return;
    eg = owner < 0 ? '0 : N'(1) << owner;
    chk("grant", grant, eg);
    chk("busy", busy, owner >= 0);
    chk("tx_start", tx_start, pend);
    if (pend) chk("tx_din", tx_din, exp_din);
    chk("req_ready", req_ready, (owner >= 0 && want) ? req_valid & eg : '0);
    chk("ready_outside_grant", req_ready & ~grant, 0);
    chk("tx_start_consecutive", tx_start && prev_start, 0);
    prev_start = tx_start;
    if (req_ready != 0 && first_ready_cyc < 0) first_ready_cyc = cyc;
    if (tx_start) begin
      cd = $urandom_range(2, 6);
      tlog.push_back(tx_din);
    end
    if (gap_meas) begin
      if (grant == 0) begin
        gap_rec.push_back(gap_cnt_meas);
        gap_meas = 0;
      end else if (s_tick) gap_cnt_meas++;
    end
    pend = 0;
    if (owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (owner < 0 && req_valid[(last_owner + k) % N]) owner = (last_owner + k) % N;
      if (owner >= 0) begin
        last_owner = owner;
        want = 1;
        glog.push_back(owner);
      end
    end else if (want) begin
      if (req_valid[owner]) begin
        {out_last, exp_din} = rq[owner].pop_front();
        acc[owner] = 1;
        pend = 1;
        want = 0;
        outst = 1;
      end
    end else if (outst) begin
      if (tx_done) begin
        outst = 0;
        if (!out_last) want = 1;
        else begin
          gap_meas = 1;
          gap_cnt_meas = 0;
          if (GAP > 0) begin
            in_gap = 1;
            ticks = 0;
          end else owner = -1;
        end
      end
    end else if (in_gap && s_tick) begin
      ticks++;
      if (ticks == GAP) begin
        in_gap = 0;
        owner = -1;
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    do begin
      drive();
      observe();
      n++;
    end while (!(all_empty() && owner < 0) && n < budget);
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    repeat (3) begin
      drive();
      observe();
    end
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_din", tx_din, 8'h00);
    chk("rst_req_ready", req_ready, 0);
    reset_n = 1'b1;
    rq[0].push_back(9'h1A5); rq[0].push_back(9'h1B5);
    rq[1].push_back(9'h011); rq[1].push_back(9'h022); rq[1].push_back(9'h133);
    rq[2].push_back(9'h144);
    rq[3].push_back(9'h155);
    chk_en = 1;
    run_until_idle(2000);
    chk("a_grant_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk("a_grant_order", glog[i], exp_g[i]);
    chk("a_byte_count", tlog.size(), 7);
    for (int i = 0; i < 7 && i < tlog.size(); i++) chk("a_byte_order", tlog[i], exp_t[i]);
    chk("a_ready_delay", first_ready_cyc - first_valid_cyc, 1);
    chk("a_gap_ticks", gap_rec.size() > 0 ? gap_rec[0] : -1, 4);
    glog.delete(); tlog.delete();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 12; p++) begin
        int len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
        total += len;
      end
    rand_mode = 1;
    run_until_idle(30000);
    chk("b_byte_count", tlog.size(), total);
    rand_mode = 0;
    for (int i = 0; i < N; i++) stall[i] = 0;
    glog.delete(); tlog.delete();
    rq[2].push_back(9'h061); rq[2].push_back(9'h162);
    for (int n = 0; n < 200 && rq[2].size() != 1; n++) begin
      drive();
      observe();
    end
    stall[2] = 50;
    rq[0].push_back(9'h170);
    rq[1].push_back(9'h171);
    run_until_idle(2000);
    chk("c_byte_count", tlog.size(), 4);
    for (int i = 0; i < 4 && i < tlog.size(); i++) chk("c_byte_order", tlog[i], exp_c[i]);
    chk("c_first_owner", glog.size() > 0 ? glog[0] : -1, 2);
    rq[1].push_back(9'h081); rq[1].push_back(9'h082); rq[1].push_back(9'h183);
    rq[0].push_back(9'h190);
    for (int n = 0; n < 500 && !(outst && owner == 1 && rq[1].size() == 1); n++) begin
      drive();
      observe();
    end
    drive();
    reset_n = 1'b0;
    chk_en = 0;
    observe();
    drive();
    observe();
    chk("d_rst_grant", grant, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_tx_start", tx_start, 0);
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      acc[i] = 0;
      stall[i] = 0;
    end
    owner = -1; last_owner = N - 1; want = 0; outst = 0; pend = 0; in_gap = 0;
    cd = 0; gap_meas = 0; prev_start = 0;
    req_valid = '0;
    tx_done = 1'b0;
    reset_n = 1'b1;
    glog.delete(); tlog.delete();
    rq[3].push_back(9'h1A3);
    rq[0].push_back(9'h1A0);
    chk_en = 1;
    run_until_idle(500);
    chk("d_grant_count", glog.size(), 2);
    chk("d_first_owner", glog.size() > 0 ? glog[0] : -1, 0);
    chk("d_second_owner", glog.size() > 1 ? glog[1] : -1, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
